// File: rtl/iob_cache_line_refill.sv
// Cache line refill engine: latches the victim way on a miss and invalidates it.
// It then fetches the line word by word from the back-end and revalidates the tag.
// Finally it marks the refilled way most-recently-used in the replacement policy.
module iob_cache_line_refill #(
  parameter int N_WAYS        = 8,
  parameter int NWAYS_W       = $clog2(N_WAYS),
  parameter int NLINES_W      = 7,
  parameter int WORD_OFFSET_W = 3,
  parameter int TAG_W         = 20,
  parameter int DATA_W        = 32
) (
  input  logic                                    clk_i,
  input  logic                                    arst_n_i,
  input  logic                                    miss_req_i,
  input  logic [TAG_W-1:0]                        miss_tag_i,
  input  logic [NLINES_W-1:0]                     miss_line_i,
  input  logic [NWAYS_W-1:0]                      way_select_bin_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    be_valid_o,
  output logic [TAG_W+NLINES_W+WORD_OFFSET_W-1:0] be_addr_o,
  input  logic                                    be_ready_i,
  input  logic                                    be_rvalid_i,
  input  logic [DATA_W-1:0]                       be_rdata_i,
  output logic [N_WAYS-1:0]                       dmem_we_o,
  output logic [NLINES_W+WORD_OFFSET_W-1:0]       dmem_addr_o,
  output logic [DATA_W-1:0]                       dmem_wdata_o,
  output logic [N_WAYS-1:0]                       tag_we_o,
  output logic [NLINES_W-1:0]                     tag_addr_o,
  output logic [TAG_W-1:0]                        tag_wdata_o,
  output logic                                    valid_wdata_o,
  output logic                                    pol_write_en_o,
  output logic [N_WAYS-1:0]                       pol_way_hit_o,
  output logic [NLINES_W-1:0]                     pol_line_addr_o
);

  localparam logic [WORD_OFFSET_W-1:0] LAST_WORD = {WORD_OFFSET_W{1'b1}};
  localparam logic [WORD_OFFSET_W-1:0] WORD_ONE  = {{(WORD_OFFSET_W-1){1'b0}}, 1'b1};
  localparam logic [N_WAYS-1:0]        ONE_WAY   = {{(N_WAYS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INVAL  = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UPDATE = 3'd4
  } state_t;

  state_t                     state_r, state_s;
  logic [WORD_OFFSET_W-1:0]   word_cnt_r, word_cnt_s;
  logic [TAG_W-1:0]           tag_r, tag_s;
  logic [NLINES_W-1:0]        line_r, line_s;
  logic [NWAYS_W-1:0]         way_r, way_s;
  logic [N_WAYS-1:0]          victim_s;

  assign victim_s = ONE_WAY << way_r;

  // Address and data fields come straight from the latched request; they read 0 after reset.
  assign busy_o          = (state_r != ST_IDLE);
  assign be_addr_o       = {tag_r, line_r, word_cnt_r};
  assign dmem_addr_o     = {line_r, word_cnt_r};
  assign tag_addr_o      = line_r;
  assign tag_wdata_o     = tag_r;
  assign pol_line_addr_o = line_r;

  // State and latched-request registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r    <= ST_IDLE;
      word_cnt_r <= '0;
      tag_r      <= '0;
      line_r     <= '0;
      way_r      <= '0;
    end else begin
      state_r    <= state_s;
      word_cnt_r <= word_cnt_s;
      tag_r      <= tag_s;
      line_r     <= line_s;
      way_r      <= way_s;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_s        = state_r;
    word_cnt_s     = word_cnt_r;
    tag_s          = tag_r;
    line_s         = line_r;
    way_s          = way_r;
    done_o         = 1'b0;
    be_valid_o     = 1'b0;
    dmem_we_o      = '0;
    dmem_wdata_o   = '0;
    tag_we_o       = '0;
    valid_wdata_o  = 1'b0;
    pol_write_en_o = 1'b0;
    pol_way_hit_o  = '0;

    case (state_r)
      ST_IDLE: begin
        if (miss_req_i) begin
          tag_s   = miss_tag_i;
          line_s  = miss_line_i;
          way_s   = way_select_bin_i;
          state_s = ST_INVAL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      // Drop the victim's valid bit before any partial line data is written.
      ST_INVAL: begin
        tag_we_o   = victim_s;
        word_cnt_s = '0;
        state_s    = ST_REQ;
      end
      ST_REQ: begin
        be_valid_o = 1'b1;
        if (be_ready_i) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (be_rvalid_i) begin
          dmem_we_o    = victim_s;
          dmem_wdata_o = be_rdata_i;
          if (word_cnt_r == LAST_WORD) begin
            state_s = ST_UPDATE;
          end else begin
            word_cnt_s = word_cnt_r + WORD_ONE;
            state_s    = ST_REQ;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_UPDATE: begin
        tag_we_o       = victim_s;
        valid_wdata_o  = 1'b1;
        pol_write_en_o = 1'b1;
        pol_way_hit_o  = victim_s;
        done_o         = 1'b1;
        state_s        = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule
